// File: rtl/lane_array_scanner_pkg.sv
// Shared types and helpers for the lane array scanner: FSM encoding,
// a width-safe clog2 and the array coordinate record.
package lane_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FIN     = 2'd3
  } state_e;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } coord_t;

  // A single-entry dimension still needs a 1-bit port.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lane_array_scanner_if.sv
// Increment request and scan-stream signals of the lane array scanner.
interface lane_array_scanner_if #(
  parameter int ROWS  = 3,
  parameter int COLS  = 2,
  parameter int WIDTH = 16
);
  localparam int RW = lane_array_pkg::clog2_min1(ROWS);
  localparam int CW = lane_array_pkg::clog2_min1(COLS);

  logic             start;
  logic             inc_valid;
  logic [RW-1:0]    inc_row;
  logic [CW-1:0]    inc_col;
  logic [WIDTH-1:0] inc_data;
  logic             inc_err;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_row;
  logic [CW-1:0]    out_col;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    output start, inc_valid, inc_row, inc_col, inc_data, out_ready,
    input  inc_err, out_valid, out_row, out_col, out_data, out_last, busy, done
  );

  modport slave (
    input  start, inc_valid, inc_row, inc_col, inc_data, out_ready,
    output inc_err, out_valid, out_row, out_col, out_data, out_last, busy, done
  );

endinterface

// File: rtl/lane_array_scanner_cell.sv
// One array element: an accumulator that wraps modulo 2^WIDTH and resets
// to its own identity value INIT.
module lane_cell #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_val,
  output logic [WIDTH-1:0] val
);

  logic [WIDTH-1:0] r_val;

  always_ff @(posedge clk) begin
    if (rst)
      r_val <= INIT;
    else if (add_en)
      r_val <= r_val + add_val;
  end

  assign val = r_val;

endmodule

// File: rtl/lane_array_scanner.sv
// ROWS x COLS array of accumulators with addressed increments and a
// row-major scan engine presenting snapshots on a valid/ready stream.
module lane_array_scanner #(
  parameter int ROWS  = 3,
  parameter int COLS  = 2,
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  lane_array_scanner_if.slave bus
);
  import lane_array_pkg::*;

  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(COLS);

  logic             w_inc_ok;
  logic             w_inc_hit;
  logic             w_scan_last;
  logic [WIDTH-1:0] w_sel_val;
  logic             w_add_en [ROWS][COLS];
  logic [WIDTH-1:0] w_val    [ROWS][COLS];

  state_e           r_state;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_out_row;
  logic [CW-1:0]    r_out_col;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_inc_err;

  assign w_inc_ok = bus.inc_valid
                  && ({1'b0, bus.inc_row} < (RW+1)'(ROWS))
                  && ({1'b0, bus.inc_col} < (CW+1)'(COLS));

  // Increment landing on the cell being loaded this cycle (write-first).
  assign w_inc_hit = w_inc_ok && (bus.inc_row == r_row) && (bus.inc_col == r_col);

  assign w_scan_last = (r_row == RW'(ROWS-1)) && (r_col == CW'(COLS-1));

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      assign w_add_en[gr][gc] = w_inc_ok
                              && (bus.inc_row == RW'(gr))
                              && (bus.inc_col == CW'(gc));
      lane_cell #(
        .WIDTH (WIDTH),
        .INIT  (WIDTH'(gr*COLS + gc))
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .add_en  (w_add_en[gr][gc]),
        .add_val (bus.inc_data),
        .val     (w_val[gr][gc])
      );
    end
  end

  always_comb begin
    w_sel_val = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r_row == RW'(r) && r_col == CW'(c))
          w_sel_val = w_val[r][c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_inc_err  <= 1'b0;
    end else begin
      r_inc_err <= bus.inc_valid && !w_inc_ok;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_out_row  <= r_row;
          r_out_col  <= r_col;
          r_out_last <= w_scan_last;
          r_out_data <= w_sel_val + (w_inc_hit ? bus.inc_data : '0);
          r_state    <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.out_ready) begin
            if (w_scan_last) begin
              r_state <= ST_FIN;
            end else begin
              if (r_col == CW'(COLS-1)) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
              r_state <= ST_LOAD;
            end
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = (r_state == ST_PRESENT);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_FIN);
  assign bus.out_row   = r_out_row;
  assign bus.out_col   = r_out_col;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.inc_err   = r_inc_err;

endmodule

// File: tb/tb_lane_array_scanner.sv
// Scoreboard bench for lane_array_scanner: default 3x2x16 instance plus a
// 4x1x8 instance sharing clock and reset.
module tb_lane_array_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_array_scanner_if #(.ROWS(3), .COLS(2), .WIDTH(16)) bus_a ();
  lane_array_scanner_if #(.ROWS(4), .COLS(1), .WIDTH(8))  bus_b ();

  lane_array_scanner #(.ROWS(3), .COLS(2), .WIDTH(16)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  lane_array_scanner #(.ROWS(4), .COLS(1), .WIDTH(8)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  typedef struct {
    int row;
    int col;
    int data;
    bit last;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_b[$];
  logic [15:0] model [6];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) model[i] = 16'(i);
  endtask

  task automatic push_scan();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        sb.push_back('{r, c, int'(model[r*2+c]), (r == 2 && c == 1)});
  endtask

  task automatic idle_inputs();
    bus_a.start = 0; bus_a.inc_valid = 0; bus_a.inc_row = 0; bus_a.inc_col = 0;
    bus_a.inc_data = 0; bus_a.out_ready = 0;
    bus_b.start = 0; bus_b.inc_valid = 0; bus_b.inc_row = 0; bus_b.inc_col = 0;
    bus_b.inc_data = 0; bus_b.out_ready = 0;
  endtask

  // Full scan of dut_a; optional hold at element hold_idx with one increment
  // issued during the hold, optional stray start pulses while busy.
  task automatic do_scan(input int hold_idx, input int hold_cyc,
                         input int inc_r, input int inc_c, input logic [15:0] inc_v,
                         input bit junk_start, output int done_cyc, output int n_done);
    int acc = 0, hold_left = hold_cyc, held = 0, k = 0;
    bit fin = 0, inc_pend = 0;
    exp_t e;
    done_cyc = -1; n_done = 0;
    @(posedge clk); #1;
    bus_a.start = 1;
    bus_a.out_ready = !(hold_idx == 0 && hold_cyc > 0);
    push_scan();
    while (!fin && k < 200) begin
      k++;
      @(posedge clk); #1;
      bus_a.start = junk_start && k >= 2 && k <= 13;
      bus_a.inc_valid = 0;
      if (inc_pend) begin
        bus_a.inc_valid = 1; bus_a.inc_row = 2'(inc_r); bus_a.inc_col = 1'(inc_c);
        bus_a.inc_data = inc_v;
        model[inc_r*2+inc_c] = model[inc_r*2+inc_c] + inc_v;
        inc_pend = 0;
      end
      bus_a.out_ready = !(acc == hold_idx && hold_left > 0);
      @(negedge clk);
      if (bus_a.done) begin n_done++; done_cyc = k; fin = 1; end
      if (bus_a.out_valid) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL scan_extra: got element with empty scoreboard");
        end else if (bus_a.out_ready) begin
          e = sb.pop_front();
          acc++;
          if (int'(bus_a.out_row) !== e.row) begin
            n_fail++; $display("FAIL out_row: got %0d expected %0d", bus_a.out_row, e.row);
          end
          n_chk++;
          if (int'(bus_a.out_col) !== e.col) begin
            n_fail++; $display("FAIL out_col: got %0d expected %0d", bus_a.out_col, e.col);
          end
          n_chk++;
          if (int'(bus_a.out_data) !== e.data) begin
            n_fail++; $display("FAIL out_data(%0d,%0d): got %0d expected %0d",
                               e.row, e.col, bus_a.out_data, e.data);
          end
          n_chk++;
          if (bus_a.out_last !== e.last) begin
            n_fail++; $display("FAIL out_last(%0d,%0d): got %0b expected %0b",
                               e.row, e.col, bus_a.out_last, e.last);
          end
        end else begin
          e = sb[0];
          if (int'(bus_a.out_data) !== e.data || int'(bus_a.out_col) !== e.col) begin
            n_fail++; $display("FAIL hold_stable: got (%0d,%0d) expected (col %0d,data %0d)",
                               bus_a.out_col, bus_a.out_data, e.col, e.data);
          end
          if (hold_left == hold_cyc) inc_pend = 1;
          hold_left--;
          held++;
        end
      end
    end
    n_chk++;
    if (!fin) begin
      n_fail++; $display("FAIL scan_timeout: got no done, expected done within 200 cycles");
    end
    if (hold_cyc > 0) begin
      n_chk++;
      if (held !== hold_cyc) begin
        n_fail++; $display("FAIL hold_cycles: got %0d expected %0d", held, hold_cyc);
      end
    end
    @(posedge clk); #1;
    bus_a.start = 0; bus_a.inc_valid = 0;
    @(negedge clk);
    n_chk++;
    if (bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_scan_idle: got busy=%0b valid=%0b expected 0/0",
                         bus_a.busy, bus_a.out_valid);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic apply_inc(input int r, input int c, input logic [15:0] v);
    bit ok = (r < 3) && (c < 2);
    @(posedge clk); #1;
    bus_a.inc_valid = 1; bus_a.inc_row = 2'(r); bus_a.inc_col = 1'(c); bus_a.inc_data = v;
    if (ok) model[r*2+c] = model[r*2+c] + v;
    @(posedge clk); #1;
    bus_a.inc_valid = 0;
    @(negedge clk);
    n_chk++;
    if (bus_a.inc_err !== !ok) begin
      n_fail++; $display("FAIL inc_err(%0d,%0d): got %0b expected %0b", r, c, bus_a.inc_err, !ok);
    end
    @(negedge clk);
    n_chk++;
    if (bus_a.inc_err !== 1'b0) begin
      n_fail++; $display("FAIL inc_err_pulse(%0d,%0d): got %0b expected 0", r, c, bus_a.inc_err);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus_a.out_valid, bus_a.out_last, bus_a.busy, bus_a.done, bus_a.inc_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %05b expected 00000",
                         {bus_a.out_valid, bus_a.out_last, bus_a.busy, bus_a.done, bus_a.inc_err});
    end
    n_chk++;
    if ({bus_a.out_row, bus_a.out_col, bus_a.out_data} !== 19'b0) begin
      n_fail++; $display("FAIL reset_out: got row %0d col %0d data %0d expected 0/0/0",
                         bus_a.out_row, bus_a.out_col, bus_a.out_data);
    end
    n_chk++;
    if (bus_b.busy !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got busy=%0b valid=%0b expected 0/0",
                         bus_b.busy, bus_b.out_valid);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_basic_scan();
    int dc, nd;
    do_scan(-1, 0, 0, 0, 16'd0, 1'b0, dc, nd);
    n_chk++;
    if (dc !== 13) begin
      n_fail++; $display("FAIL basic_done_latency: got %0d expected 13", dc);
    end
  endtask

  task automatic test_increment();
    int dc, nd;
    apply_inc(1, 1, 16'd10);
    apply_inc(2, 0, 16'hFFFF);
    n_chk++;
    if (model[3] !== 16'd13 || model[4] !== 16'd3) begin
      n_fail++; $display("FAIL model_wrap: got %0d/%0d expected 13/3", model[3], model[4]);
    end
    do_scan(-1, 0, 0, 0, 16'd0, 1'b0, dc, nd);
  endtask

  task automatic test_hold();
    int dc, nd;
    do_scan(1, 5, 0, 1, 16'd7, 1'b0, dc, nd);
    n_chk++;
    if (dc !== 18) begin
      n_fail++; $display("FAIL hold_done_latency: got %0d expected 18", dc);
    end
    n_chk++;
    if (model[1] !== 16'd8) begin
      n_fail++; $display("FAIL hold_model: got %0d expected 8", model[1]);
    end
    do_scan(-1, 0, 0, 0, 16'd0, 1'b0, dc, nd);
  endtask

  task automatic test_err_and_busy_start();
    int dc, nd;
    apply_inc(3, 0, 16'd5);
    apply_inc(3, 1, 16'd9);
    do_scan(-1, 0, 0, 0, 16'd0, 1'b1, dc, nd);
    n_chk++;
    if (nd !== 1 || dc !== 13) begin
      n_fail++; $display("FAIL busy_start: got %0d done at %0d expected 1 done at 13", nd, dc);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0, k = 0, dc, nd, bad = 0;
    bit hit = 0;
    exp_t e;
    @(posedge clk); #1;
    bus_a.start = 1; bus_a.out_ready = 1;
    push_scan();
    while (!hit && k < 50) begin
      k++;
      @(posedge clk); #1;
      bus_a.start = 0;
      bus_a.out_ready = (acc < 2);
      @(negedge clk);
      if (bus_a.out_valid) begin
        if (bus_a.out_ready) begin
          e = sb.pop_front(); acc++;
          n_chk++;
          if (int'(bus_a.out_data) !== e.data) begin
            n_fail++; $display("FAIL mid_data: got %0d expected %0d", bus_a.out_data, e.data);
          end
        end else if (acc == 2) begin
          rst = 1;
          hit = 1;
        end
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++; $display("FAIL mid_timeout: got no third element, expected one");
    end
    @(negedge clk);
    n_chk++;
    if (bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%0b busy=%0b done=%0b expected 0/0/0",
                         bus_a.out_valid, bus_a.busy, bus_a.done);
    end
    @(posedge clk); #1;
    rst = 0; bus_a.out_ready = 1;
    repeat (15) begin
      @(negedge clk);
      if (bus_a.done !== 1'b0 || bus_a.out_valid !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mid_no_done: got %0d active cycles expected 0", bad);
    end
    sb.delete();
    model_reset();
    do_scan(-1, 0, 0, 0, 16'd0, 1'b0, dc, nd);
  endtask

  task automatic test_small();
    int k = 0, dc = -1;
    exp_t e;
    @(posedge clk); #1;
    bus_b.start = 1; bus_b.out_ready = 1;
    for (int i = 0; i < 4; i++) sb_b.push_back('{i, 0, i, (i == 3)});
    while (dc < 0 && k < 100) begin
      k++;
      @(posedge clk); #1;
      bus_b.start = 0;
      @(negedge clk);
      if (bus_b.done) dc = k;
      n_chk++;
      if (bus_b.out_col !== 1'b0) begin
        n_fail++; $display("FAIL small_col: got %0d expected 0", bus_b.out_col);
      end
      if (bus_b.out_valid) begin
        n_chk++;
        if (sb_b.size() == 0) begin
          n_fail++; $display("FAIL small_extra: got element with empty scoreboard");
        end else begin
          e = sb_b.pop_front();
          if (int'(bus_b.out_row) !== e.row || int'(bus_b.out_data) !== e.data ||
              bus_b.out_last !== e.last) begin
            n_fail++; $display("FAIL small_elem: got row %0d data %0d last %0b expected %0d/%0d/%0b",
                               bus_b.out_row, bus_b.out_data, bus_b.out_last, e.row, e.data, e.last);
          end
        end
      end
    end
    n_chk++;
    if (dc !== 9) begin
      n_fail++; $display("FAIL small_done_latency: got %0d expected 9", dc);
    end
    n_chk++;
    if (sb_b.size() != 0) begin
      n_fail++; $display("FAIL small_left: got %0d expected 0", sb_b.size());
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_basic_scan();
    test_increment();
    test_hold();
    test_err_and_busy_start();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
